// File: rtl/gpio_register_bank.sv
// GPIO command decoder and readback bank for the DSP datapath.
// A command word {opcode, strobe, data} runs once on each rising edge of the strobe bit.
// It can write the reset, enable and phase control registers, latch every wide counter
// into a snapshot, and return 32-bit slices of that snapshot.
// Optional feature macro MEM_LOG_EN builds a sample-capture log memory with an
// IDLE/CAPTURE/DONE FSM that the processor can arm, stop and read back.
// Without the macro the LOG op type is a no-op, and log_busy and log_full are tied 0.
module gpio_register_bank #(
  parameter int unsigned GPIO_LEN     = 32,
  parameter int unsigned OPCODE_LEN   = 8,
  parameter int unsigned OP_TYPE_LEN  = 2,
  parameter int unsigned NUM_CH       = 4,
  parameter int unsigned COUNT_LEN    = 64,
  parameter int unsigned ENABLE_LEN   = 3,
  parameter int unsigned PHASE_LEN    = 2,
  parameter int unsigned LOG_DEPTH    = 1024,
  parameter int unsigned LOG_DATA_LEN = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [GPIO_LEN-1:0]         gpio_in,
  output logic [GPIO_LEN-1:0]         gpio_out,
  input  logic [NUM_CH*COUNT_LEN-1:0] count_in,
  input  logic [LOG_DATA_LEN-1:0]     log_data_in,
  input  logic                        log_valid_in,
  output logic                        reset_reg,
  output logic [ENABLE_LEN-1:0]       enable_reg,
  output logic [PHASE_LEN-1:0]        phase_reg,
  output logic                        log_busy,
  output logic                        log_full
);

  localparam int unsigned WORDS      = COUNT_LEN / GPIO_LEN;
  localparam int unsigned NUM_SLICES = NUM_CH * WORDS;
  localparam int unsigned DATA_LEN   = GPIO_LEN - OPCODE_LEN - 1;
  localparam int unsigned CODE_LEN   = OPCODE_LEN - OP_TYPE_LEN;
  localparam int unsigned ADDR_LEN   = $clog2(LOG_DEPTH);
  // One extra bit so a full log reports a pointer equal to LOG_DEPTH.
  localparam int unsigned PTR_LEN    = ADDR_LEN + 1;

  localparam logic [OP_TYPE_LEN-1:0] OpReg   = OP_TYPE_LEN'(0);
  localparam logic [OP_TYPE_LEN-1:0] OpCount = OP_TYPE_LEN'(2);
  localparam logic [OP_TYPE_LEN-1:0] OpLog   = OP_TYPE_LEN'(3);
  localparam logic [CODE_LEN-1:0]    CodeAll = {CODE_LEN{1'b1}};

`ifdef MEM_LOG_EN
  localparam bit LogEn = 1'b1;
`else
  localparam bit LogEn = 1'b0;
`endif

  logic [OPCODE_LEN-1:0]        opcode;
  logic [OP_TYPE_LEN-1:0]       op_type;
  logic [CODE_LEN-1:0]          code;
  logic                         strobe;
  logic [DATA_LEN-1:0]          data;
  logic                         strobe_q;
  logic                         exec;
  logic [NUM_CH*COUNT_LEN-1:0]  snap_q;
  logic [GPIO_LEN-1:0]          count_word;
  logic                         log_rd_pend;
  logic [GPIO_LEN-1:0]          log_rd_word;
  logic [GPIO_LEN-1:0]          log_status;
  logic                         unused_sig;

  assign opcode  = gpio_in[GPIO_LEN-1 -: OPCODE_LEN];
  assign op_type = opcode[OPCODE_LEN-1 -: OP_TYPE_LEN];
  assign code    = opcode[CODE_LEN-1:0];
  assign strobe  = gpio_in[DATA_LEN];
  assign data    = gpio_in[DATA_LEN-1:0];
  assign exec    = strobe & ~strobe_q;

  // Only some data bits are decoded; the log inputs are idle without the log feature.
  assign unused_sig = ^{data, log_data_in, log_valid_in};

  // Select snapshot slice for a COUNT read; slice 0 of a channel is its most significant word.
  always_comb begin
    count_word = '0;
    for (int s = 0; s < NUM_SLICES; s++) begin
      if (code == CODE_LEN'(s)) begin
        count_word = snap_q[(s / WORDS) * COUNT_LEN + (WORDS - 1 - (s % WORDS)) * GPIO_LEN
                            +: GPIO_LEN];
      end
    end
  end

  // Command decode: control registers, counter snapshot and readback word.
  always_ff @(posedge clk) begin
    if (rst) begin
      strobe_q   <= 1'b1;
      reset_reg  <= 1'b0;
      enable_reg <= '0;
      phase_reg  <= '0;
      gpio_out   <= '0;
      snap_q     <= '0;
    end else begin
      strobe_q <= strobe;
      if (log_rd_pend) begin
        gpio_out <= log_rd_word;
      end
      if (exec) begin
        case (op_type)
          OpReg: begin
            if (code == CODE_LEN'(0)) begin
              reset_reg <= data[0];
            end else if (code == CODE_LEN'(1)) begin
              enable_reg <= data[ENABLE_LEN-1:0];
            end else if (code == CODE_LEN'(2)) begin
              phase_reg <= data[PHASE_LEN-1:0];
            end else if (code == CodeAll) begin
              gpio_out <= GPIO_LEN'({phase_reg, enable_reg, reset_reg});
            end
          end
          OpCount: begin
            if (code == CodeAll) begin
              snap_q <= count_in;
            end else begin
              gpio_out <= count_word;
            end
          end
          OpLog: begin
            if (LogEn && code == CODE_LEN'(2)) begin
              gpio_out <= log_status;
            end
          end
          default: ;
        endcase
      end
    end
  end

`ifdef MEM_LOG_EN
  typedef enum logic [1:0] {StIdle, StCapture, StDone} log_state_e;

  log_state_e                log_state;
  logic [PTR_LEN-1:0]        wr_ptr;
  logic [LOG_DATA_LEN-1:0]   mem [LOG_DEPTH];
  logic [LOG_DEPTH-1:0]      written_q;
  logic [LOG_DATA_LEN-1:0]   rd_data_q;
  logic                      rd_hit_q;
  logic                      rd_pend_q;
  logic                      log_cmd;
  logic                      cmd_arm;
  logic                      cmd_stop;
  logic                      cmd_read;
  logic                      log_wr;
  logic [ADDR_LEN-1:0]       rd_addr;
  logic [ADDR_LEN-1:0]       wr_addr;

  assign log_cmd  = exec && (op_type == OpLog);
  assign cmd_arm  = log_cmd && (code == CODE_LEN'(0));
  assign cmd_read = log_cmd && (code == CODE_LEN'(1));
  assign cmd_stop = log_cmd && (code == CODE_LEN'(3));
  // Samples coinciding with ARM or STOP are dropped so the pointer stays consistent.
  assign log_wr   = (log_state == StCapture) && log_valid_in && !cmd_arm && !cmd_stop;
  assign rd_addr  = data[ADDR_LEN-1:0];
  assign wr_addr  = wr_ptr[ADDR_LEN-1:0];

  // Capture FSM with registered busy/full flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      log_state <= StIdle;
      wr_ptr    <= '0;
      log_busy  <= 1'b0;
      log_full  <= 1'b0;
    end else if (cmd_arm) begin
      log_state <= StCapture;
      wr_ptr    <= '0;
      log_busy  <= 1'b1;
      log_full  <= 1'b0;
    end else if (cmd_stop && log_state == StCapture) begin
      log_state <= StDone;
      log_busy  <= 1'b0;
    end else if (log_wr) begin
      wr_ptr <= wr_ptr + PTR_LEN'(1);
      if (wr_ptr == PTR_LEN'(LOG_DEPTH - 1)) begin
        log_state <= StDone;
        log_busy  <= 1'b0;
        log_full  <= 1'b1;
      end
    end
  end

  // Sample memory: write port from capture, synchronous read port from READ.
  always_ff @(posedge clk) begin
    if (log_wr) begin
      mem[wr_addr] <= log_data_in;
    end
    if (cmd_read) begin
      rd_data_q <= mem[rd_addr];
    end
  end

  // Written flags make never-captured addresses read as 0; read pipeline stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      written_q <= '0;
      rd_hit_q  <= 1'b0;
      rd_pend_q <= 1'b0;
    end else begin
      rd_pend_q <= cmd_read;
      if (cmd_read) begin
        rd_hit_q <= written_q[rd_addr];
      end
      if (log_wr) begin
        written_q[wr_addr] <= 1'b1;
      end
    end
  end

  assign log_rd_pend = rd_pend_q;
  assign log_rd_word = rd_hit_q ? GPIO_LEN'(rd_data_q) : '0;

  // STATUS word: full and busy in the top bits, write pointer in the LSBs.
  always_comb begin
    log_status               = '0;
    log_status[GPIO_LEN-1]   = log_full;
    log_status[GPIO_LEN-2]   = log_busy;
    log_status[PTR_LEN-1:0]  = wr_ptr;
  end
`else
  assign log_busy    = 1'b0;
  assign log_full    = 1'b0;
  assign log_rd_pend = 1'b0;
  assign log_rd_word = '0;
  assign log_status  = '0;
`endif

endmodule

// File: tb/tb_gpio_register_bank.sv
// Directed bench for gpio_register_bank with a scoreboard for readback words.
module tb_gpio_register_bank;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  gpio_in;
  logic [31:0]  gpio_out;
  logic [255:0] count_in;
  logic [15:0]  log_data_in;
  logic         log_valid_in;
  logic         reset_reg;
  logic [2:0]   enable_reg;
  logic [1:0]   phase_reg;
  logic         log_busy;
  logic         log_full;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;
  exp_t sb[$];

  gpio_register_bank dut (
    .clk          (clk),
    .rst          (rst),
    .gpio_in      (gpio_in),
    .gpio_out     (gpio_out),
    .count_in     (count_in),
    .log_data_in  (log_data_in),
    .log_valid_in (log_valid_in),
    .reset_reg    (reset_reg),
    .enable_reg   (enable_reg),
    .phase_reg    (phase_reg),
    .log_busy     (log_busy),
    .log_full     (log_full)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic pop_check();
    exp_t e;
    e = sb.pop_front();
    chk(e.tag, 64'(gpio_out), 64'(e.val));
  endtask

  // Drop strobe for one cycle, raise it, return #1 after the execute edge.
  task automatic cmd(input logic [7:0] op, input logic [22:0] d);
    @(negedge clk);
    gpio_in = {op, 1'b0, d};
    @(negedge clk);
    gpio_in = {op, 1'b1, d};
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst          = 1'b1;
    gpio_in      = {8'h01, 1'b1, 23'd5};
    count_in     = '0;
    log_data_in  = '0;
    log_valid_in = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    // Strobe held through reset must not execute.
    chk("rst_enable", 64'(enable_reg), 64'd0);
    chk("rst_reset", 64'(reset_reg), 64'd0);
    chk("rst_phase", 64'(phase_reg), 64'd0);
    chk("rst_gpio_out", 64'(gpio_out), 64'd0);
    chk("rst_busy", 64'(log_busy), 64'd0);
    chk("rst_full", 64'(log_full), 64'd0);

    cmd(8'h01, 23'd5);
    chk("enable_5", 64'(enable_reg), 64'd5);
    // Data changes while strobe stays high must be ignored.
    @(negedge clk);
    gpio_in = {8'h01, 1'b1, 23'd2};
    repeat (10) @(posedge clk);
    #1;
    chk("enable_hold", 64'(enable_reg), 64'd5);

    cmd(8'h00, 23'd1);
    chk("reset_reg_1", 64'(reset_reg), 64'd1);
    cmd(8'h02, 23'd2);
    chk("phase_2", 64'(phase_reg), 64'd2);
    cmd(8'h01, 23'd6);
    chk("enable_6", 64'(enable_reg), 64'd6);
    expect_out("reg_readback", 32'h0000_002D);
    cmd(8'h3F, 23'd0);
    pop_check();
    cmd(8'h05, 23'd7);
    chk("reg_undef_en", 64'(enable_reg), 64'd6);
    cmd(8'h41, 23'd1);
    chk("optype01_rst", 64'(reset_reg), 64'd1);
    expect_out("optype01_out", 32'h0000_002D);
    pop_check();

    count_in = {64'hDEAD_BEEF_CAFE_F00D, 64'h0123_4567_89AB_CDEF,
                64'h5555_6666_7777_8888, 64'h0000_1111_2222_3333};
    cmd(8'hBF, 23'd0);
    count_in = {4{64'hFFFF_0000_FFFF_0000}};
    expect_out("cnt_code4", 32'h0123_4567);
    cmd(8'h84, 23'd0);
    pop_check();
    expect_out("cnt_code5", 32'h89AB_CDEF);
    cmd(8'h85, 23'd0);
    pop_check();
    expect_out("cnt_code8", 32'h0000_0000);
    cmd(8'h88, 23'd0);
    pop_check();
    expect_out("cnt_code0", 32'h0000_1111);
    cmd(8'h80, 23'd0);
    pop_check();
    expect_out("cnt_code3", 32'h7777_8888);
    cmd(8'h83, 23'd0);
    pop_check();
    expect_out("cnt_code7", 32'hCAFE_F00D);
    cmd(8'h87, 23'd0);
    pop_check();

`ifdef MEM_LOG_EN
    // Unwritten address reads 0; gpio_out holds its old value one edge after execute.
    cmd(8'hC1, 23'd5);
    chk("read_lat1", 64'(gpio_out), 64'(32'hCAFE_F00D));
    expect_out("read_unwritten", 32'h0);
    @(posedge clk);
    #1;
    pop_check();

    log_valid_in = 1'b1;
    log_data_in  = 16'hAAAA;
    cmd(8'hC0, 23'd0);
    log_valid_in = 1'b0;
    chk("arm_busy", 64'(log_busy), 64'd1);
    expect_out("arm_status", 32'h4000_0000);
    cmd(8'hC2, 23'd0);
    pop_check();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      log_valid_in = 1'b1;
      log_data_in  = 16'h0100 + 16'(i);
    end
    @(negedge clk);
    log_valid_in = 1'b0;
    cmd(8'hC3, 23'd0);
    chk("stop_busy", 64'(log_busy), 64'd0);
    chk("stop_full", 64'(log_full), 64'd0);
    expect_out("stop_status", 32'h0000_000A);
    cmd(8'hC2, 23'd0);
    pop_check();
    expect_out("read_addr3", 32'h0000_0103);
    cmd(8'hC1, 23'd3);
    @(posedge clk);
    #1;
    pop_check();
    cmd(8'hC0, 23'd0);
    expect_out("rearm_status", 32'h4000_0000);
    cmd(8'hC2, 23'd0);
    pop_check();

    for (int i = 0; i < 1024; i++) begin
      @(negedge clk);
      log_valid_in = 1'b1;
      log_data_in  = 16'(i);
    end
    @(negedge clk);
    log_valid_in = 1'b0;
    begin
      int budget = 20;
      while (!log_full && budget > 0) begin
        @(posedge clk);
        #1;
        budget--;
      end
    end
    chk("fill_full", 64'(log_full), 64'd1);
    chk("fill_busy", 64'(log_busy), 64'd0);
    @(negedge clk);
    log_valid_in = 1'b1;
    log_data_in  = 16'hBEEF;
    @(negedge clk);
    log_valid_in = 1'b0;
    expect_out("full_status", 32'h8000_0400);
    cmd(8'hC2, 23'd0);
    pop_check();
    cmd(8'hC1, 23'h3FF);
    chk("read3ff_lat1", 64'(gpio_out), 64'(32'h8000_0400));
    expect_out("read_3ff", 32'h0000_03FF);
    @(posedge clk);
    #1;
    pop_check();
    expect_out("read_0", 32'h0000_0000);
    cmd(8'hC1, 23'd0);
    @(posedge clk);
    #1;
    pop_check();
`else
    cmd(8'hC0, 23'd0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      log_valid_in = 1'b1;
      log_data_in  = 16'(i);
    end
    @(negedge clk);
    log_valid_in = 1'b0;
    chk("nolog_busy", 64'(log_busy), 64'd0);
    chk("nolog_full", 64'(log_full), 64'd0);
    cmd(8'hC2, 23'd0);
    expect_out("nolog_status", 32'hCAFE_F00D);
    pop_check();
    cmd(8'hC1, 23'd0);
    @(posedge clk);
    #1;
    expect_out("nolog_read", 32'hCAFE_F00D);
    pop_check();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
